// File: rtl/reg_dump.sv
// Walks register-file entries 0..Depth-1 and streams them out over a valid/ready port.
// Optional macro REG_DUMP_CHECKSUM_EN appends an XOR checksum word after the last register.
module reg_dump #(
    parameter int DataWidth    = 32,
    parameter int Depth        = 32,
    parameter int Addres_depth = 5
) (
    input  logic                    clk,
    input  logic                    RST,
    input  logic                    start,
    output logic [Addres_depth-1:0] rf_addr,
    input  logic [DataWidth-1:0]    rf_data,
    output logic [DataWidth-1:0]    dout,
    output logic [Addres_depth-1:0] dout_addr,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic                    dout_csum,
    output logic                    busy,
    output logic                    done,
    output logic [2:0]              dbg_state
);

    // Handshake: a word transfers on a rising edge where dout_valid and dout_ready are both 1;
    // while dout_valid=1 and dout_ready=0, dout/dout_addr/dout_csum hold unchanged.

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SEND  = 3'd2,
        CSUM  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [Addres_depth-1:0] LastIdx = Addres_depth'(Depth - 1);

    state_t                  state, state_n;
    logic [Addres_depth-1:0] index;
    logic                    accept, capture, advance, send_hs, load_csum, close_csum;
    logic [DataWidth-1:0]    csum_word;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n    = state;
        accept     = 1'b0;
        capture    = 1'b0;
        advance    = 1'b0;
        send_hs    = 1'b0;
        load_csum  = 1'b0;
        close_csum = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_n = FETCH;
                end
            end
            FETCH: begin
                capture = 1'b1;
                state_n = SEND;
            end
            SEND: begin
                if (dout_ready) begin
                    send_hs = 1'b1;
                    if (index < LastIdx) begin
                        advance = 1'b1;
                        state_n = FETCH;
                    end else begin
`ifdef REG_DUMP_CHECKSUM_EN
                        load_csum = 1'b1;
                        state_n   = CSUM;
`else
                        state_n   = DONE;
`endif
                    end
                end
            end
            CSUM: begin
                if (dout_ready) begin
                    close_csum = 1'b1;
                    state_n    = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            index      <= '0;
            dout       <= '0;
            dout_addr  <= '0;
            dout_valid <= 1'b0;
        end else begin
            if (accept)       index <= '0;
            else if (advance) index <= index + 1'b1;

            if (capture) begin
                dout       <= rf_data;
                dout_addr  <= index;
                dout_valid <= 1'b1;
            end else if (load_csum) begin
                // Last data word handshakes here; valid stays high into the checksum word.
                dout      <= csum_word;
                dout_addr <= '0;
            end else if (send_hs || close_csum) begin
                dout_valid <= 1'b0;
            end
        end
    end

`ifdef REG_DUMP_CHECKSUM_EN
    logic [DataWidth-1:0] csum;

    assign csum_word = csum ^ dout;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            csum      <= '0;
            dout_csum <= 1'b0;
        end else begin
            if (accept)       csum <= '0;
            else if (send_hs) csum <= csum ^ dout;

            if (load_csum)       dout_csum <= 1'b1;
            else if (close_csum) dout_csum <= 1'b0;
        end
    end
`else
    assign csum_word = '0;
    assign dout_csum = 1'b0;
`endif

    assign rf_addr   = index;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_reg_dump.sv
// Bench for reg_dump: randomized register contents and ready patterns checked against a
// queue of expected words built from the register array when each dump is requested.
module tb_reg_dump;
    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int EW    = 1 + AW + DW;
`ifdef REG_DUMP_CHECKSUM_EN
    localparam int CSUM_EXTRA = 1;
`else
    localparam int CSUM_EXTRA = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;
    logic [DW-1:0] dout;
    logic [AW-1:0] dout_addr;
    logic          dout_valid;
    logic          dout_ready;
    logic          dout_csum;
    logic          busy;
    logic          done;
    logic [2:0]    dbg_state;

    logic [DW-1:0] regs [DEPTH];
    logic [EW-1:0] exp_q [$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cnt = 0;
    bit model_busy = 1'b0;
    int ready_mode = 0;
    int stall_addr = 0;
    int stall_left = 0;

    reg_dump #(.DataWidth(DW), .Depth(DEPTH), .Addres_depth(AW)) dut (
        .clk        (clk),
        .RST        (rst),
        .start      (start),
        .rf_addr    (rf_addr),
        .rf_data    (rf_data),
        .dout       (dout),
        .dout_addr  (dout_addr),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_csum  (dout_csum),
        .busy       (busy),
        .done       (done),
        .dbg_state  (dbg_state)
    );

    assign rf_data = regs[rf_addr];

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // consumer ready driver
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1: dout_ready = ($urandom_range(0, 3) != 0);
            2: begin
                if (dout_valid && !dout_csum && dout_addr == AW'(stall_addr) && stall_left > 0) begin
                    dout_ready = 1'b0;
                    stall_left--;
                end else begin
                    dout_ready = 1'b1;
                end
            end
            default: dout_ready = 1'b1;
        endcase
    end

    // scoreboard: every presented word must match the queue head; pop on handshake
    always @(negedge clk) begin
        if (!rst) begin
            if (dout_valid) begin
                check("word_pending", 64'(exp_q.size() > 0), 64'(1));
                if (exp_q.size() > 0) begin
                    check("word", 64'({dout_csum, dout_addr, dout}), 64'(exp_q[0]));
                    if (dout_ready) void'(exp_q.pop_front());
                end
            end
            if (done) begin
                done_cnt++;
                model_busy = 1'b0;
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_dout"},       64'(dout),       64'(0));
        check({tag, "_dout_addr"},  64'(dout_addr),  64'(0));
        check({tag, "_dout_valid"}, 64'(dout_valid), 64'(0));
        check({tag, "_dout_csum"},  64'(dout_csum),  64'(0));
        check({tag, "_busy"},       64'(busy),       64'(0));
        check({tag, "_done"},       64'(done),       64'(0));
        check({tag, "_rf_addr"},    64'(rf_addr),    64'(0));
    endtask

    // start driver; the model accepts a request only when no dump is in progress
    task automatic start_pulse(input bit release_rst);
        logic [DW-1:0] x;
        @(posedge clk);
        #1;
        if (release_rst) rst = 1'b0;
        start = 1'b1;
        if (!model_busy) begin
            model_busy = 1'b1;
            start_cyc  = cyc + 1;
            x = '0;
            for (int i = 0; i < DEPTH; i++) begin
                exp_q.push_back({1'b0, AW'(i), regs[i]});
                x ^= regs[i];
            end
`ifdef REG_DUMP_CHECKSUM_EN
            exp_q.push_back({1'b1, AW'(0), x});
`endif
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (done) begin
                lat = cyc - start_cyc;
                break;
            end
        end
        if (lat < 0) check("done_timeout", 64'(0), 64'(1));
    endtask

    task automatic run_dump(input string tag, input int mode, input bit chk_lat, input bit release_rst);
        int d0;
        int lat;
        ready_mode = mode;
        d0 = done_cnt;
        start_pulse(release_rst);
        wait_done(lat);
        if (chk_lat) check({tag, "_latency"}, 64'(lat), 64'(2 * DEPTH + CSUM_EXTRA));
        repeat (3) @(negedge clk);
        check({tag, "_queue_left"}, 64'(exp_q.size()), 64'(0));
        check({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'(1));
        check({tag, "_busy_after"}, 64'(busy), 64'(0));
    endtask

    task automatic wait_word(input int addr, output bit found);
        found = 1'b0;
        for (int n = 0; n < 2000 && !found; n++) begin
            @(negedge clk);
            if (dout_valid && !dout_csum && dout_addr == AW'(addr)) found = 1'b1;
        end
        if (!found) check("wait_word_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        bit found;
        int d0;
        logic [DW-1:0] saved;

        rst        = 1'b1;
        start      = 1'b0;
        dout_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) regs[i] = DW'(32'h100 + i);

        repeat (3) @(posedge clk);
        #2 check_idle_outputs("reset");

        // first dump, start raised together with reset release
        run_dump("incr", 0, 1'b1, 1'b1);

        // five-cycle stall on word 3
        stall_addr = 3;
        stall_left = 5;
        run_dump("stall3", 2, 1'b0, 1'b0);
        check("stall3_used", 64'(stall_left), 64'(0));

        // register changes while word 5 is being held
        stall_addr = 5;
        stall_left = 4;
        saved = regs[5];
        fork
            run_dump("hold5", 2, 1'b0, 1'b0);
            begin
                wait_word(5, found);
                regs[5] = ~regs[5];
            end
        join
        regs[5] = saved;

        // second start while busy must not be queued
        fork
            run_dump("busy_start", 0, 1'b1, 1'b0);
            begin
                wait_word(10, found);
                start_pulse(1'b0);
            end
        join

        // asynchronous reset in the middle of word 7
        ready_mode = 0;
        start_pulse(1'b0);
        wait_word(7, found);
        #2 rst = 1'b1;
        exp_q.delete();
        model_busy = 1'b0;
        d0 = done_cnt;
        #1 check_idle_outputs("async_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        check("async_rst_no_done", 64'(done_cnt - d0), 64'(0));
        check("async_rst_idle", 64'(busy), 64'(0));
        run_dump("after_rst", 0, 1'b1, 1'b0);

        // checksum pattern
        for (int i = 0; i < DEPTH; i++) regs[i] = '0;
        regs[0] = 32'h1;
        regs[1] = 32'h2;
        regs[2] = 32'h4;
        run_dump("csum_pat", 0, 1'b1, 1'b0);

        // random contents with random back-pressure
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < DEPTH; i++) regs[i] = $urandom;
            run_dump("random", 1, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
